// File: rtl/burst_pkg.sv
// Shared types for the 64-bit burst memory interface.
// Imported by the responder and by cacheline_adaptor.
package burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } resp_fsm_t;

  function automatic int beats(int s_offset);
    return (2 ** s_offset) / 8;
  endfunction

endpackage

// File: rtl/burst_mem_array.sv
// Single-port 64-bit word store with a synchronous write and a registered read.
// The read register is cleared by reset, but the array contents are not.
module burst_mem_array #(
  parameter int mem_w = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [mem_w-1:0] addr,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  logic [63:0] mem [2**mem_w];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/burst_mem_responder.sv
// Responder for cacheline bursts: serves BEATS 64-bit beats per line request
// after a fixed latency, backed by burst_mem_array.
module burst_mem_responder
  import burst_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int mem_w    = 10,
  parameter int LATENCY  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o,
  output logic        err_o
);

  localparam int BEATS = beats(s_offset);
  localparam int BTW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int LCW = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;
  localparam logic [mem_w-1:0] LMASK = mem_w'(BEATS - 1);

  resp_fsm_t        state;
  resp_fsm_t        nxt;
  logic             op_rd;
  logic [mem_w-1:0] base;
  logic [BTW-1:0]   beat;
  logic [LCW-1:0]   lat_cnt;
  logic             err;

  logic             req;
  logic             held;
  logic             last;
  logic             rd_sel;
  logic             we;
  logic             re;
  logic [mem_w-1:0] in_idx;
  logic [mem_w-1:0] addr;
  logic             unused_addr;

  assign unused_addr = ^{address_i[31:mem_w+3], address_i[2:0]};

  assign req    = read_i | write_i;
  assign held   = op_rd ? read_i : write_i;
  assign last   = beat == BTW'(BEATS - 1);
  assign in_idx = address_i[mem_w+2:3] & ~LMASK;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (req) nxt = (LATENCY > 0) ? WAIT : BURST;
      WAIT: begin
        if (!held) nxt = DONE;
        else if (lat_cnt == LCW'(LATENCY)) nxt = BURST;
      end
      BURST: if (!held || last) nxt = DONE;
      DONE:  nxt = IDLE;
    endcase
  end

  // Reads fetch one word ahead so burst_o loads on the edge raising resp_o.
  assign rd_sel = (state == IDLE) ? read_i : op_rd;
  assign re     = rd_sel && (nxt == BURST);
  assign we     = (state == BURST) && !op_rd && held;

  always_comb begin
    addr = base;
    unique case (state)
      IDLE:  addr = in_idx;
      BURST: addr = base + mem_w'(beat) + mem_w'(op_rd);
      default: addr = base;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_rd   <= 1'b0;
      base    <= '0;
      beat    <= '0;
      lat_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: begin
          if (req) begin
            op_rd   <= read_i;
            base    <= in_idx;
            beat    <= '0;
            lat_cnt <= LCW'(1);
            if (read_i && write_i) err <= 1'b1;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (!held) err <= 1'b1;
        end
        BURST: begin
          beat <= beat + 1'b1;
          if (!held) err <= 1'b1;
        end
        DONE: begin
        end
      endcase
    end
  end

  burst_mem_array #(
    .mem_w(mem_w)
  ) u_mem (
    .clk  (clk),
    .rst_n(reset_n),
    .we   (we),
    .re   (re),
    .addr (addr),
    .wdata(burst_i),
    .rdata(burst_o)
  );

  assign resp_o = state == BURST;
  assign err_o  = err;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: u0 at LATENCY=4, u1 at LATENCY=0.
module tb_burst_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [63:0] bi = '0;

  logic [31:0] addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [63:0] bo;
  logic        resp;
  logic        err;

  logic [31:0] addr1 = '0;
  logic        rd1 = 1'b0;
  logic        wr1 = 1'b0;
  logic [63:0] bo1;
  logic        resp1;
  logic        err1;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  burst_mem_responder #(
    .s_offset(5), .mem_w(10), .LATENCY(4)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .address_i(addr),
    .read_i(rd), .write_i(wr), .burst_i(bi),
    .burst_o(bo), .resp_o(resp), .err_o(err)
  );

  burst_mem_responder #(
    .s_offset(5), .mem_w(10), .LATENCY(0)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .address_i(addr1),
    .read_i(rd1), .write_i(wr1), .burst_i(bi),
    .burst_o(bo1), .resp_o(resp1), .err_o(err1)
  );

  task automatic apply_reset();
    rd = 0; wr = 0; rd1 = 0; wr1 = 0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drop_req();
    rd = 0; wr = 0; rd1 = 0; wr1 = 0;
  endtask

  task automatic do_write(input bit sel, input logic [31:0] a,
                          input logic [3:0][63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    if (sel) begin addr1 = a; wr1 = 1; end
    else begin addr = a; wr = 1; end
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(negedge clk);
      if (sel ? resp1 : resp) begin
        bi = d[n];
        n++;
      end
    end
    @(negedge clk);
    drop_req();
    @(negedge clk);
  endtask

  task automatic do_read(input bit sel, input logic [31:0] a,
                         input bit both,
                         output logic [3:0][63:0] q,
                         output int first, output int last);
    int n;
    n = 0; first = -1; last = -1; q = '0;
    @(negedge clk);
    bi = 64'hDEAD_BEEF_0BAD_F00D;
    if (sel) begin addr1 = a; rd1 = 1; wr1 = both; end
    else begin addr = a; rd = 1; wr = both; end
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(negedge clk);
      if (sel ? resp1 : resp) begin
        if (first < 0) first = k;
        last = k;
        q[n] = sel ? bo1 : bo;
        n++;
      end
    end
    @(negedge clk);
    drop_req();
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if (resp !== 1'b0) $display("FAIL rst_resp got %b want 0", resp);
    else pass_cnt++;
    total++;
    if (bo !== 64'h0) $display("FAIL rst_burst got %h want 0", bo);
    else pass_cnt++;
    total++;
    if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err);
    else pass_cnt++;
    total++;
    if (resp1 !== 1'b0) $display("FAIL rst_resp1 got %b want 0", resp1);
    else pass_cnt++;
  endtask

  task automatic test_read_latency();
    logic [3:0][63:0] d, q;
    int f, l;
    d = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    do_write(0, 32'h200, d);
    do_read(0, 32'h200, 0, q, f, l);
    total++;
    if (f !== 5) $display("FAIL rd_first got %0d want 5", f);
    else pass_cnt++;
    total++;
    if (l !== 8) $display("FAIL rd_last got %0d want 8", l);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (q[i] !== d[i])
        $display("FAIL rd_beat%0d got %h want %h", i, q[i], d[i]);
      else pass_cnt++;
    end
    total++;
    if (bo !== 64'hA3) $display("FAIL rd_hold got %h want a3", bo);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    logic [3:0][63:0] d, q, q2;
    int f, l;
    d = {64'h44, 64'h33, 64'h22, 64'h11};
    do_write(0, 32'h1E0, d);
    do_read(0, 32'h1E0, 0, q, f, l);
    do_read(0, 32'h1E8, 0, q2, f, l);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (q[i] !== d[i])
        $display("FAIL wr_beat%0d got %h want %h", i, q[i], d[i]);
      else pass_cnt++;
      total++;
      if (q2[i] !== d[i])
        $display("FAIL off_beat%0d got %h want %h", i, q2[i], d[i]);
      else pass_cnt++;
    end
    total++;
    if (err !== 1'b0) $display("FAIL wr_err got %b want 0", err);
    else pass_cnt++;
  endtask

  task automatic test_zero_latency();
    logic [3:0][63:0] d, q;
    logic [11:0] vec;
    logic [63:0] b10;
    int f, l;
    d = {64'h8, 64'h7, 64'h6, 64'h5};
    do_write(1, 32'h40, d);
    do_read(1, 32'h40, 0, q, f, l);
    total++;
    if (f !== 1) $display("FAIL z_first got %0d want 1", f);
    else pass_cnt++;
    total++;
    if (l !== 4) $display("FAIL z_last got %0d want 4", l);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (q[i] !== d[i])
        $display("FAIL z_beat%0d got %h want %h", i, q[i], d[i]);
      else pass_cnt++;
    end
    // Request held through DONE: one DONE and one IDLE cycle between bursts.
    vec = '0; b10 = '0;
    @(negedge clk);
    addr1 = 32'h40; rd1 = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      vec[k-1] = resp1;
      if (k == 10) b10 = bo1;
    end
    drop_req();
    @(negedge clk);
    total++;
    if (vec !== 12'h3CF) $display("FAIL b2b_resp got %h want 3cf", vec);
    else pass_cnt++;
    total++;
    if (b10 !== 64'h8) $display("FAIL b2b_data got %h want 8", b10);
    else pass_cnt++;
  endtask

  task automatic test_rd_wr_conflict();
    logic [3:0][63:0] d, q, q2;
    int f, l;
    d = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    do_write(0, 32'h0, d);
    do_read(0, 32'h0, 1, q, f, l);
    total++;
    if (err !== 1'b1) $display("FAIL cf_err got %b want 1", err);
    else pass_cnt++;
    do_read(0, 32'h0, 0, q2, f, l);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (q[i] !== d[i])
        $display("FAIL cf_beat%0d got %h want %h", i, q[i], d[i]);
      else pass_cnt++;
      total++;
      if (q2[i] !== d[i])
        $display("FAIL cf_keep%0d got %h want %h", i, q2[i], d[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    logic [3:0][63:0] d, e, q;
    int f, l, n;
    apply_reset();
    d = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    e = {64'hD3, 64'hD2, 64'hE1, 64'hE0};
    do_write(0, 32'h100, d);
    total++;
    if (err !== 1'b0) $display("FAIL ab_pre_err got %b want 0", err);
    else pass_cnt++;
    @(negedge clk);
    addr = 32'h100; wr = 1; n = 0;
    for (int k = 1; k <= 40 && n < 3; k++) begin
      @(negedge clk);
      if (resp) begin
        n++;
        if (n == 1) bi = 64'hE0;
        else if (n == 2) bi = 64'hE1;
        else begin bi = 64'hFF; wr = 0; end
      end
    end
    @(negedge clk);
    total++;
    if (resp !== 1'b0) $display("FAIL ab_resp got %b want 0", resp);
    else pass_cnt++;
    total++;
    if (err !== 1'b1) $display("FAIL ab_err got %b want 1", err);
    else pass_cnt++;
    @(negedge clk);
    do_read(0, 32'h100, 0, q, f, l);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (q[i] !== e[i])
        $display("FAIL ab_word%0d got %h want %h", i, q[i], e[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0][63:0] q;
    int f, l, n;
    apply_reset();
    @(negedge clk);
    addr = 32'h200; rd = 1; wr = 1; n = 0;
    for (int k = 1; k <= 40 && n < 2; k++) begin
      @(negedge clk);
      if (resp) n++;
    end
    total++;
    if (err !== 1'b1 || n !== 2)
      $display("FAIL mr_pre got err=%b n=%0d want 1/2", err, n);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (resp !== 1'b0) $display("FAIL mr_resp got %b want 0", resp);
    else pass_cnt++;
    total++;
    if (bo !== 64'h0) $display("FAIL mr_burst got %h want 0", bo);
    else pass_cnt++;
    total++;
    if (err !== 1'b0) $display("FAIL mr_err got %b want 0", err);
    else pass_cnt++;
    drop_req();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_read(0, 32'h200, 0, q, f, l);
    total++;
    if (f !== 5 || l !== 8)
      $display("FAIL mr_timing got %0d..%0d want 5..8", f, l);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (q[i] !== 64'(8'hA0 + i))
        $display("FAIL mr_beat%0d got %h want %h", i, q[i], 8'hA0 + i);
      else pass_cnt++;
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_read_latency();
    test_write_read();
    test_zero_latency();
    test_rd_wr_conflict();
    test_abort();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
